mux2_stream_arbiter: RTL

- Round-robin, packet-locked arbiter that shares one 2:1 datapath mux between two valid/ready requester streams (A, B) and one downstream consumer.
- Produces the mux select, gates the requester ready signals and drives a one-deep registered output stage.
- Sits directly in front of the shared 2:1 mux. The mux convention is fixed: sel=1 passes A, sel=0 passes B.

---
 rtl/mux2_stream_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/mux2_stream_arbiter.sv
// rtl/mux2_stream_arbiter.sv - round-robin packet-locked arbiter for a shared 2:1 stream mux
// Grants one source for a whole packet, then returns to IDLE and hands priority to the other.
module mux2_stream_arbiter #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] a_data,
  input  logic             a_valid,
  input  logic             a_last,
  output logic             a_ready,
  input  logic [width-1:0] b_data,
  input  logic             b_valid,
  input  logic             b_last,
  output logic             b_ready,
  output logic [width-1:0] m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  output logic             sel,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_t;

  state_t state, state_nx;
  logic   prio_a, prio_a_nx;
  logic   sel_nx;
  logic   out_free;
  logic   acc_a, acc_b;

  // The output register can take a beat when empty or draining this cycle.
  assign out_free = !m_valid || m_ready;
  assign acc_a    = a_valid && a_ready;
  assign acc_b    = b_valid && b_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      prio_a <= 1'b1;
      sel    <= 1'b0;
    end else begin
      state  <= state_nx;
      prio_a <= prio_a_nx;
      sel    <= sel_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    prio_a_nx = prio_a;
    sel_nx    = sel;
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (a_valid && (!b_valid || prio_a)) state_nx = LOCK_A;
        else if (b_valid)                    state_nx = LOCK_B;
      end
      LOCK_A: begin
        a_ready = out_free;
        if (a_valid && out_free && a_last) begin
          state_nx  = IDLE;
          prio_a_nx = 1'b0;
        end
      end
      LOCK_B: begin
        b_ready = out_free;
        if (b_valid && out_free && b_last) begin
          state_nx  = IDLE;
          prio_a_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    // sel tracks the grant and keeps its last value through IDLE.
    if (state_nx == LOCK_A)      sel_nx = 1'b1;
    else if (state_nx == LOCK_B) sel_nx = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data  <= '0;
      m_last  <= 1'b0;
      m_valid <= 1'b0;
    end else if (acc_a) begin
      m_data  <= a_data;
      m_last  <= a_last;
      m_valid <= 1'b1;
    end else if (acc_b) begin
      m_data  <= b_data;
      m_last  <= b_last;
      m_valid <= 1'b1;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule
